bit_stream_framer: RTL and testbench
====================================

// Module: bit_stream_framer
// PURPOSE
//   Consumes the 1-bit registered stream produced by the d-flip-flop stage (q) and frames it.
//   Hunts for a SYNC word in the serial stream, then deserializes the next FRAME_WORDS
//   words of W bits each into parallel words, then returns to hunting.
//   Sits directly downstream of the block/nonblock DFF stage; one clock domain.
// PARAMETERS
//   W           4        word width in bits; also SYNC width (W >= 2)
//   SYNC        4'b1011  sync word; MSB is the first bit received
//   FRAME_WORDS 2        data words per frame after sync (>= 1)
//   CNT_W       8        width of frame_cnt
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   din         in   1      serial data bit (from DFF stage q)
//   din_valid   in   1      din sampled only when 1
//   clear       in   1      synchronous soft reset
//   locked      out  1      1 while in LOCK state
//   sync_pulse  out  1      1-cycle pulse: SYNC found
//   par_out     out  W      last completed data word; MSB = first bit received
//   par_valid   out  1      1-cycle pulse: par_out updated
//   frame_done  out  1      1-cycle pulse: last word of frame completed
//   frame_cnt   out  CNT_W  completed frames, saturating
// BEHAVIOUR
//   Reset (rst=1, async): state=HUNT; shreg, fill, bit_cnt, word_cnt = 0;
//     every output = 0. Takes effect immediately, including mid-frame.
//   clear=1 at a clock edge: same values as reset, synchronously.
//     clear wins over din_valid in the same cycle; that bit is discarded.
//   din_valid=0: state, shreg and counters hold; all pulse outputs deassert.
//   Every valid bit shifts in: shreg <= {shreg[W-2:0], din}; nxt = {shreg[W-2:0], din}.
//   HUNT: fill counts valid bits, saturating at W.
//     Sync hit when nxt==SYNC and fill>=W-1 (W fresh bits including the current one).
//     Hunting is overlapping: a partial match may share bits with the next attempt.
//     On a hit: sync_pulse=1 and locked=1 from the next cycle; state=LOCK;
//     bit_cnt=0, word_cnt=0.
//   LOCK: bit_cnt counts valid bits 0..W-1.
//     When a valid bit arrives with bit_cnt==W-1: par_out<=nxt, par_valid=1 next cycle;
//     bit_cnt=0; word_cnt++.
//   Completing word FRAME_WORDS-1 in the same edge also does the following:
//     frame_done=1; frame_cnt++ (holds at 2^CNT_W-1); state=HUNT; locked=0 next cycle;
//     fill=0, so the next sync needs W fresh bits and never reuses data bits.
//   Latency: all outputs registered, 1 cycle after the edge that samples the deciding bit.
//   par_out holds its value between par_valid pulses.
//   sync_pulse and par_valid are never high in the same cycle.
// TESTING  (W=4, SYNC=1011, FRAME_WORDS=2 unless stated)
//   1. Valid bits 1,0,1,1 | 0,1,1,0 | 1,1,0,0 -> sync_pulse after bit 4;
//      par_out=0110 with par_valid after bit 8;
//      par_out=1100 with par_valid + frame_done after bit 12; frame_cnt=1; locked=0.
//   2. After reset: 0,1,0,1,1 -> sync_pulse only after bit 5; 1,0,1,0,1,1 -> after bit 6.
//   3. Test 1 stream with din_valid=0 for 3 cycles between each bit -> identical outputs;
//      pulses last 1 cycle; nothing changes during gaps.
//   4. In LOCK after 2 data bits, clear=1 with din_valid=1 -> next cycle locked=0,
//      frame_cnt=0; a fresh full 1011 is required to lock.
//   5. rst asserted mid-word between edges -> locked, par_out, frame_cnt = 0 at once;
//      restart after release passes test 1.
//   6. CNT_W=2: send 5 complete frames -> frame_cnt = 1,2,3,3,3; frame_done pulses 5 times.

Source files
------------

// File: rtl/bit_stream_framer.sv
// Serial framer: hunts for a SYNC word in a gated bit stream, then deserializes
// FRAME_WORDS words of W bits (MSB first) and returns to hunting.
module bit_stream_framer #(
    parameter int             W           = 4,
    parameter logic [W-1:0]   SYNC        = 4'b1011,
    parameter int             FRAME_WORDS = 2,
    parameter int             CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             sync_pulse,
    output logic [W-1:0]     par_out,
    output logic             par_valid,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int FILL_W = $clog2(W + 1);
    localparam int BIT_W  = $clog2(W);
    localparam int WORD_W = $clog2(FRAME_WORDS + 1);

    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(W);
    localparam logic [FILL_W-1:0] FILL_HIT  = FILL_W'(W - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(W - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_WORDS - 1);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    // locked is the registered copy of state and serves as its observable view.
    state_t              state;
    logic [W-1:0]        shreg;
    logic [FILL_W-1:0]   fill;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WORD_W-1:0]   word_cnt;
    logic [W-1:0]        nxt;

    always_comb begin
        nxt = {shreg[W-2:0], din};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            shreg      <= '0;
            fill       <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            locked     <= 1'b0;
            sync_pulse <= 1'b0;
            par_out    <= '0;
            par_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else if (clear) begin
            state      <= HUNT;
            shreg      <= '0;
            fill       <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            locked     <= 1'b0;
            sync_pulse <= 1'b0;
            par_out    <= '0;
            par_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            sync_pulse <= 1'b0;
            par_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (din_valid) begin
                shreg <= nxt;
                case (state)
                    HUNT: begin
                        // fill >= W-1 means the current bit completes W fresh bits.
                        if (nxt == SYNC && fill >= FILL_HIT) begin
                            state      <= LOCK;
                            locked     <= 1'b1;
                            sync_pulse <= 1'b1;
                            bit_cnt    <= '0;
                            word_cnt   <= '0;
                        end else if (fill < FILL_MAX) begin
                            fill <= fill + 1'b1;
                        end
                    end
                    LOCK: begin
                        if (bit_cnt == BIT_LAST) begin
                            par_out   <= nxt;
                            par_valid <= 1'b1;
                            bit_cnt   <= '0;
                            if (word_cnt == WORD_LAST) begin
                                frame_done <= 1'b1;
                                if (frame_cnt != {CNT_W{1'b1}}) begin
                                    frame_cnt <= frame_cnt + 1'b1;
                                end
                                state    <= HUNT;
                                locked   <= 1'b0;
                                fill     <= '0;
                                word_cnt <= '0;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bit_stream_framer.sv
// Bench for bit_stream_framer: a bit-level reference model feeds an expected-output
// queue each cycle; a second instance with CNT_W=2 shares the stimulus.
module tb_bit_stream_framer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       clear = 1'b0;
    logic       locked, sync_pulse, par_valid, frame_done;
    logic [3:0] par_out;
    logic [7:0] frame_cnt;
    logic       locked2, sync_pulse2, par_valid2, frame_done2;
    logic [3:0] par_out2;
    logic [1:0] frame_cnt2;

    always #5 clk = ~clk;

    bit_stream_framer dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(locked), .sync_pulse(sync_pulse), .par_out(par_out),
        .par_valid(par_valid), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    bit_stream_framer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(locked2), .sync_pulse(sync_pulse2), .par_out(par_out2),
        .par_valid(par_valid2), .frame_done(frame_done2), .frame_cnt(frame_cnt2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fd_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the framer, tracked bit by bit.
    logic       m_locked, m_sp, m_pv, m_fd;
    logic [3:0] m_par, m_hist;
    logic [7:0] m_cnt;
    logic [1:0] m_cnt2;
    int         m_fresh, m_bitpos, m_word;

    // {locked, sync_pulse, par_valid, frame_done, par_out, frame_cnt, frame_cnt2}
    logic [17:0] exp_q[$];

    task automatic model_reset();
        m_locked = 0; m_sp = 0; m_pv = 0; m_fd = 0;
        m_par = '0; m_hist = '0; m_cnt = '0; m_cnt2 = '0;
        m_fresh = 0; m_bitpos = 0; m_word = 0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic c);
        if (c) begin
            model_reset();
            return;
        end
        m_sp = 0; m_pv = 0; m_fd = 0;
        if (!v) return;
        m_hist = {m_hist[2:0], b};
        if (!m_locked) begin
            if (m_hist == 4'b1011 && m_fresh >= 3) begin
                m_locked = 1; m_sp = 1; m_bitpos = 0; m_word = 0;
            end else if (m_fresh < 4) begin
                m_fresh++;
            end
        end else begin
            m_bitpos++;
            if (m_bitpos == 4) begin
                m_bitpos = 0;
                m_par = m_hist;
                m_pv = 1;
                m_word++;
                if (m_word == 2) begin
                    m_fd = 1;
                    m_word = 0;
                    m_locked = 0;
                    m_fresh = 0;
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                    if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
                end
            end
        end
    endtask

    task automatic compare_out();
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("locked",     locked,      e[17]);
        check("sync_pulse", sync_pulse,  e[16]);
        check("par_valid",  par_valid,   e[15]);
        check("frame_done", frame_done,  e[14]);
        check("par_out",    par_out,     e[13:10]);
        check("frame_cnt",  frame_cnt,   e[9:2]);
        check("frame_cnt2", frame_cnt2,  e[1:0]);
        check("frame_done2", frame_done2, e[14]);
        check("locked2",    locked2,     e[17]);
        if (frame_done) fd_seen++;
    endtask

    task automatic cycle(input logic v, input logic b, input logic c);
        @(negedge clk);
        din_valid = v;
        din = b;
        clear = c;
        model_step(v, b, c);
        exp_q.push_back({m_locked, m_sp, m_pv, m_fd, m_par, m_cnt, m_cnt2});
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic send_word(input logic [3:0] w, input int gap);
        for (int i = 3; i >= 0; i--) begin
            cycle(1'b1, w[i], 1'b0);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_frame(input int gap);
        send_word(4'b1011, gap);
        send_word(4'b0110, gap);
        send_word(4'b1100, gap);
    endtask

    task automatic do_rst();
        @(negedge clk);
        din_valid = 1'b0;
        clear = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_locked", locked, 0);
        check("rst_par_out", par_out, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_frame_cnt2", frame_cnt2, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        check("init_locked", locked, 0);
        check("init_par_out", par_out, 0);
        check("init_frame_cnt", frame_cnt, 0);
        check("init_sync_pulse", sync_pulse, 0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: basic frame
        send_frame(0);
        check("t1_par_out", par_out, 4'b1100);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_locked", locked, 0);
        cycle(1'b0, 1'b0, 1'b0);

        // Test 2: overlapping hunt after reset
        do_rst();
        send_word(4'b0101, 0);
        check("t2_no_sync", locked, 0);
        cycle(1'b1, 1'b1, 1'b0);
        check("t2_sync5", sync_pulse, 1);
        do_rst();
        send_word(4'b1010, 0);
        cycle(1'b1, 1'b1, 1'b0);
        check("t2_no_sync6", locked, 0);
        cycle(1'b1, 1'b1, 1'b0);
        check("t2_sync6", sync_pulse, 1);

        // Test 3: gapped stream
        do_rst();
        send_frame(3);
        check("t3_par_out", par_out, 4'b1100);
        check("t3_frame_cnt", frame_cnt, 1);

        // Test 4: clear mid-word in LOCK
        send_word(4'b1011, 0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        check("t4_locked", locked, 0);
        check("t4_frame_cnt", frame_cnt, 0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("t4_still_hunting", locked, 0);
        send_word(4'b1011, 0);
        check("t4_relock", locked, 1);

        // Test 5: async reset mid-word, then clean restart
        cycle(1'b1, 1'b0, 1'b0);
        do_rst();
        send_frame(0);
        check("t5_frame_cnt", frame_cnt, 1);

        // Test 6: saturation of the 2-bit counter
        do_rst();
        fd_seen = 0;
        for (int f = 0; f < 5; f++) send_frame(f % 2);
        check("t6_frame_cnt2", frame_cnt2, 3);
        check("t6_frame_cnt", frame_cnt, 5);
        check("t6_done_pulses", fd_seen, 5);

        // Random traffic with gaps and occasional clear
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 149) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
